// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared fetch-stage constants, FSM encoding and next-PC selector
package cpu_defs;

  localparam int PC_WIDTH     = 16;
  localparam int INSTR_WIDTH  = 10;
  localparam int OFFSET_WIDTH = 8;
  localparam int COUNT_WIDTH  = 16;

  localparam logic [PC_WIDTH-1:0]    RESET_PC   = 16'h0000;
  localparam logic [INSTR_WIDTH-1:0] HALT_INSTR = 10'h3FF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef enum logic [1:0] {
    NEXT_HOLD   = 2'd0,
    NEXT_INC    = 2'd1,
    NEXT_JUMP   = 2'd2,
    NEXT_BRANCH = 2'd3
  } next_sel_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: redirect/stall in, ROM port, IR out to decode
interface fetch_unit_if;
  import cpu_defs::*;

  logic                    stall;
  logic                    jump_valid;
  logic [PC_WIDTH-1:0]     jump_target;
  logic                    branch_taken;
  logic [OFFSET_WIDTH-1:0] branch_offset;
  logic [PC_WIDTH-1:0]     pc_out;
  logic [INSTR_WIDTH-1:0]  instr_in;
  logic [INSTR_WIDTH-1:0]  ir_out;
  logic [PC_WIDTH-1:0]     ir_pc;
  logic                    ir_valid;
  logic                    halted;
  logic [COUNT_WIDTH-1:0]  fetch_count;

  modport master (
    output stall, jump_valid, jump_target, branch_taken, branch_offset, instr_in,
    input  pc_out, ir_out, ir_pc, ir_valid, halted, fetch_count
  );

  modport slave (
    input  stall, jump_valid, jump_target, branch_taken, branch_offset, instr_in,
    output pc_out, ir_out, ir_pc, ir_valid, halted, fetch_count
  );

endinterface

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational next-PC mux: hold, increment, absolute jump, relative branch
module pc_next_calc
  import cpu_defs::*;
(
  input  next_sel_t               sel,
  input  logic [PC_WIDTH-1:0]     pc,
  input  logic [PC_WIDTH-1:0]     base,
  input  logic [PC_WIDTH-1:0]     target,
  input  logic [OFFSET_WIDTH-1:0] offset,
  output logic [PC_WIDTH-1:0]     next_pc
);

  logic [PC_WIDTH-1:0] offset_ext;

  assign offset_ext = {{(PC_WIDTH-OFFSET_WIDTH){offset[OFFSET_WIDTH-1]}}, offset};

  // Additions truncate to PC_WIDTH, so 0xFFFF+1 and negative offsets wrap naturally.
  always_comb begin
    next_pc = pc;
    case (sel)
      NEXT_HOLD:   next_pc = pc;
      NEXT_INC:    next_pc = pc + PC_WIDTH'(1);
      NEXT_JUMP:   next_pc = target;
      NEXT_BRANCH: next_pc = base + offset_ext;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register and instruction fetch with stall, redirect flush, halt and fetch counter
module fetch_unit
  import cpu_defs::*;
(
  input logic         clock,
  input logic         reset,
  fetch_unit_if.slave bus
);

  fetch_state_t           state, state_next;
  next_sel_t              sel;
  logic [PC_WIDTH-1:0]    pc_r, pc_next;
  logic [INSTR_WIDTH-1:0] ir_r, ir_next;
  logic [PC_WIDTH-1:0]    ir_pc_r, ir_pc_next;
  logic                   ir_valid_r, ir_valid_next;
  logic                   halted_r, halted_next;
  logic [COUNT_WIDTH-1:0] count_r, count_next;

  pc_next_calc u_pc_next (
    .sel     (sel),
    .pc      (pc_r),
    .base    (ir_pc_r),
    .target  (bus.jump_target),
    .offset  (bus.branch_offset),
    .next_pc (pc_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      pc_r       <= RESET_PC;
      ir_r       <= '0;
      ir_pc_r    <= '0;
      ir_valid_r <= 1'b0;
      halted_r   <= 1'b0;
      count_r    <= '0;
    end else begin
      state      <= state_next;
      pc_r       <= pc_next;
      ir_r       <= ir_next;
      ir_pc_r    <= ir_pc_next;
      ir_valid_r <= ir_valid_next;
      halted_r   <= halted_next;
      count_r    <= count_next;
    end
  end

  // Redirect outranks stall and an incoming halt; a stall holds everything.
  always_comb begin
    state_next    = state;
    sel           = NEXT_HOLD;
    ir_next       = ir_r;
    ir_pc_next    = ir_pc_r;
    ir_valid_next = ir_valid_r;
    halted_next   = halted_r;
    count_next    = count_r;
    case (state)
      RUN: begin
        if (bus.jump_valid) begin
          sel           = NEXT_JUMP;
          ir_valid_next = 1'b0;
        end else if (bus.branch_taken) begin
          sel           = NEXT_BRANCH;
          ir_valid_next = 1'b0;
        end else if (!bus.stall) begin
          ir_next       = bus.instr_in;
          ir_pc_next    = pc_r;
          ir_valid_next = 1'b1;
          if (count_r != {COUNT_WIDTH{1'b1}}) begin
            count_next = count_r + COUNT_WIDTH'(1);
          end
          if (bus.instr_in == HALT_INSTR) begin
            state_next  = HALTED;
            halted_next = 1'b1;
          end else begin
            sel = NEXT_INC;
          end
        end
      end
      HALTED: begin
        ir_valid_next = 1'b0;
      end
    endcase
  end

  assign bus.pc_out      = pc_r;
  assign bus.ir_out      = ir_r;
  assign bus.ir_pc       = ir_pc_r;
  assign bus.ir_valid    = ir_valid_r;
  assign bus.halted      = halted_r;
  assign bus.fetch_count = count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a cycle-level reference model
module tb_fetch_unit;
  import cpu_defs::*;

  logic clock;
  logic reset;
  logic halt_en;
  logic check_en;
  int   n_checks;
  int   n_pass;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction ROM: non-halt words everywhere except address 7 when halt_en is set.
  function automatic logic [INSTR_WIDTH-1:0] rom_word(input logic [PC_WIDTH-1:0] a, input logic h);
    if (h && a == 16'd7) return HALT_INSTR;
    return {a[5:0], 4'hA};
  endfunction

  assign bus.instr_in = rom_word(bus.pc_out, halt_en);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: architectural state advanced from the fetch rules each edge.
  logic [PC_WIDTH-1:0]    m_pc;
  logic [INSTR_WIDTH-1:0] m_ir;
  logic [INSTR_WIDTH-1:0] m_word;
  logic [PC_WIDTH-1:0]    m_ir_pc;
  logic                   m_valid;
  logic                   m_halted;
  int                     m_cnt;

  always @(posedge clock) begin
    if (reset) begin
      m_pc = RESET_PC; m_ir = '0; m_ir_pc = '0; m_valid = 1'b0; m_halted = 1'b0; m_cnt = 0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (bus.jump_valid) begin
      m_pc = bus.jump_target;
      m_valid = 1'b0;
    end else if (bus.branch_taken) begin
      m_pc = 16'((int'(m_ir_pc) + int'($signed(bus.branch_offset))) & 32'hFFFF);
      m_valid = 1'b0;
    end else if (!bus.stall) begin
      m_word  = rom_word(m_pc, halt_en);
      m_ir    = m_word;
      m_ir_pc = m_pc;
      m_valid = 1'b1;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (m_word == 10'h3FF) m_halted = 1'b1;
      else m_pc = 16'((int'(m_pc) + 1) % 65536);
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      check("model pc_out",      32'(bus.pc_out),      32'(m_pc));
      check("model ir_out",      32'(bus.ir_out),      32'(m_ir));
      check("model ir_pc",       32'(bus.ir_pc),       32'(m_ir_pc));
      check("model ir_valid",    32'(bus.ir_valid),    32'(m_valid));
      check("model halted",      32'(bus.halted),      32'(m_halted));
      check("model fetch_count", 32'(bus.fetch_count), 32'(m_cnt));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    check_en = 1'b0;
    halt_en  = 1'b0;
    reset    = 1'b1;
    bus.stall         = 1'b0;
    bus.jump_valid    = 1'b0;
    bus.jump_target   = '0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = '0;
    tick(2);
    check("reset pc_out",   32'(bus.pc_out), 32'h0);
    check("reset ir_valid", 32'(bus.ir_valid), 32'h0);
    check("reset halted",   32'(bus.halted), 32'h0);
    check("reset count",    32'(bus.fetch_count), 32'h0);
    check("reset ir_out",   32'(bus.ir_out), 32'h0);
    reset    = 1'b0;
    check_en = 1'b1;

    tick(3);
    check("run3 pc_out", 32'(bus.pc_out), 32'h3);
    check("run3 ir_pc",  32'(bus.ir_pc), 32'h2);
    check("run3 count",  32'(bus.fetch_count), 32'h3);

    bus.stall = 1'b1;
    tick(3);
    check("stall pc_out", 32'(bus.pc_out), 32'h3);
    check("stall ir_out", 32'(bus.ir_out), 32'h02A);
    check("stall ir_pc",  32'(bus.ir_pc), 32'h2);
    check("stall count",  32'(bus.fetch_count), 32'h3);
    bus.stall = 1'b0;
    tick(2);
    check("resume pc_out", 32'(bus.pc_out), 32'h5);
    check("resume ir_pc",  32'(bus.ir_pc), 32'h4);
    check("resume ir_out", 32'(bus.ir_out), 32'h04A);
    check("resume count",  32'(bus.fetch_count), 32'h5);

    tick(6);
    check("pre-branch ir_pc", 32'(bus.ir_pc), 32'hA);
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 8'hFC;
    tick(1);
    check("branch pc_out",   32'(bus.pc_out), 32'h6);
    check("branch ir_valid", 32'(bus.ir_valid), 32'h0);
    check("branch ir_out",   32'(bus.ir_out), 32'h0AA);
    bus.branch_taken = 1'b0;
    tick(1);
    check("branch target ir_pc", 32'(bus.ir_pc), 32'h6);
    check("branch target valid", 32'(bus.ir_valid), 32'h1);
    check("branch count",        32'(bus.fetch_count), 32'hC);

    bus.jump_valid   = 1'b1;
    bus.jump_target  = 16'h0100;
    bus.branch_taken = 1'b1;
    bus.stall        = 1'b1;
    tick(1);
    check("jump-wins pc_out", 32'(bus.pc_out), 32'h100);
    bus.branch_taken = 1'b0;
    bus.stall        = 1'b0;
    bus.jump_target  = 16'hFFFF;
    tick(1);
    check("jump ffff pc_out", 32'(bus.pc_out), 32'hFFFF);
    bus.jump_valid = 1'b0;
    tick(1);
    check("wrap pc_out 0", 32'(bus.pc_out), 32'h0);
    check("wrap ir_pc",    32'(bus.ir_pc), 32'hFFFF);
    tick(1);
    check("wrap pc_out 1", 32'(bus.pc_out), 32'h1);
    check("wrap ir_pc 0",  32'(bus.ir_pc), 32'h0);

    check_en  = 1'b0;
    bus.stall = 1'b1;
    force dut.count_r = 16'hFFFD;
    tick(1);
    release dut.count_r;
    m_cnt     = 65533;
    check_en  = 1'b1;
    bus.stall = 1'b0;
    tick(1);
    check("sat count fffe", 32'(bus.fetch_count), 32'hFFFE);
    tick(2);
    check("sat count ffff", 32'(bus.fetch_count), 32'hFFFF);

    halt_en         = 1'b1;
    bus.jump_valid  = 1'b1;
    bus.jump_target = 16'h0005;
    tick(1);
    bus.jump_valid = 1'b0;
    tick(2);
    check("at halt addr pc_out", 32'(bus.pc_out), 32'h7);
    bus.jump_valid = 1'b1;
    tick(1);
    check("redirect beats halt", 32'(bus.halted), 32'h0);
    check("redirect beats pc",   32'(bus.pc_out), 32'h5);
    bus.jump_valid = 1'b0;
    tick(3);
    check("halt ir_out",   32'(bus.ir_out), 32'h3FF);
    check("halt ir_valid", 32'(bus.ir_valid), 32'h1);
    check("halt halted",   32'(bus.halted), 32'h1);
    check("halt pc_out",   32'(bus.pc_out), 32'h7);
    tick(1);
    check("halted ir_valid", 32'(bus.ir_valid), 32'h0);
    for (int i = 0; i < 10; i++) begin
      bus.jump_valid   = i[0];
      bus.jump_target  = 16'h1234;
      bus.branch_taken = 1'b1;
      bus.stall        = i[1];
      tick(1);
      check("halted pc frozen", 32'(bus.pc_out), 32'h7);
    end
    bus.jump_valid   = 1'b0;
    bus.branch_taken = 1'b0;
    check("halted count held", 32'(bus.fetch_count), 32'hFFFF);

    bus.stall = 1'b1;
    reset     = 1'b1;
    tick(1);
    check("midreset pc_out",   32'(bus.pc_out), 32'h0);
    check("midreset halted",   32'(bus.halted), 32'h0);
    check("midreset ir_valid", 32'(bus.ir_valid), 32'h0);
    check("midreset count",    32'(bus.fetch_count), 32'h0);
    reset     = 1'b0;
    bus.stall = 1'b0;
    tick(2);
    check("post-reset pc_out", 32'(bus.pc_out), 32'h2);
    check("post-reset count",  32'(bus.fetch_count), 32'h2);

    @(negedge clock);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
